ret_addr_stack: RTL and testbench
=================================

Name: ret_addr_stack

Overview:
- Hardware return-address stack.
- Responder to the controller's `stack_push` / `stack_pop` strobes: a jump-to-subroutine pushes the return PC, and a return pops it.
- Sits beside the PC register. Its `top_addr` feeds the PC-source mux input selected by `pc_src` = 2'b10.
- Sequential storage with occupancy tracking, sticky error flags and defined simultaneous-event behaviour.

Parameters:
- ADDR_W, 12, width of a stored return address (PC width).
- DEPTH, 8, number of entries; must be a power of two, at least 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  synchronous, active-high reset.
- push  input  1  push `push_addr` this cycle (driven from `stack_push`).
- pop  input  1  pop the top entry this cycle (driven from `stack_pop`).
- push_addr  input  ADDR_W  return address to store (PC+1 from datapath).
- top_addr  output  ADDR_W  current top entry; combinational read; 0 when empty.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- count  output  CNT_W  number of valid entries.
- overflow  output  1  sticky: push refused (or oldest entry dropped) while full.
- underflow  output  1  sticky: pop requested while empty.

Behaviour:
- Reset (`rst` high at posedge): `sp` = 0, `count` = 0, `overflow` = 0, `underflow` = 0.
  - Memory contents are don't-care.
  - Outputs after reset: `top_addr` = 0, `empty` = 1, `full` = 0.
  - `rst` wins over `push` and `pop` in the same cycle, including mid-sequence.
- Storage: DEPTH x ADDR_W array, indexed by write pointer `sp` (next free slot).
  - `top_addr` = mem[sp-1] when count > 0, else 0.
  - `top_addr` is a same-cycle combinational read, so the PC mux samples the return address in the same cycle `pop` is asserted.
- Pop latency: the entry is removed at the posedge ending the pop cycle. The next cycle's `top_addr` shows the new top.
- Push latency: the written value is visible on `top_addr` the cycle after `push`.
- Per-cycle cases (no reset):
  - push only, not full: mem[sp] <= `push_addr`; sp <= sp+1; count+1.
  - push only, full: no state change; `overflow` <= 1 (see optional feature).
  - pop only, count > 0: sp <= sp-1; count-1. Memory is untouched.
  - pop only, empty: no state change; `underflow` <= 1.
  - push and pop, count > 0: mem[sp-1] <= `push_addr` (replace top); sp and count unchanged. No flag, even when full.
  - push and pop, empty: treated as push only; `underflow` <= 1.
  - neither: hold.
- Pointer arithmetic is modulo DEPTH (sp is $clog2(DEPTH) bits). `count` is the authoritative occupancy; full/empty are never derived from sp alone.
- `overflow` and `underflow` clear only on `rst`.

Optional Feature:
- Macro: RET_STACK_CIRCULAR_EN.
- Defined:
  - A push-only while full writes mem[sp]; sp <= sp+1, which overwrites the oldest entry. `count` stays DEPTH.
  - `overflow` <= 1 still, marking the lost oldest return.
  - A deep recursion therefore keeps the most recent DEPTH returns.
- Undefined: a push while full is refused as described above.

Decomposition:
- Shared package `ret_stack_pkg`: ADDR_W default, DEPTH default, and a `stack_op_t` enum {OP_NONE, OP_PUSH, OP_POP, OP_REPLACE} derived from {push, pop}. The same package is used by the bench scoreboard.
- One natural sub-module: `ret_stack_mem`, a DEPTH x ADDR_W array with a synchronous write port and an asynchronous read port.
- Pointer, count and flag logic stay in the top.

Test Plan:
- Reset then idle: `rst` = 1 for 2 cycles -> `count` = 0, `empty` = 1, `full` = 0, `top_addr` = 0, both flags 0.
- LIFO order: push 0x010, 0x020, 0x030 on 3 consecutive cycles -> `count` = 3, `top_addr` = 0x030. Then pop x3 -> `top_addr` reads 0x030, 0x020, 0x010 in the pop cycles; `empty` = 1 after.
- Fill and overflow: push 0x100..0x107 (8 pushes) -> `full` = 1. Push 0x1FF ->
  - default build: `overflow` = 1, `top_addr` stays 0x107, `count` = 8.
  - with RET_STACK_CIRCULAR_EN: `top_addr` = 0x1FF, `count` = 8; 8 pops yield 0x1FF, 0x107..0x101.
- Underflow: from reset, pop -> `underflow` = 1, `count` = 0, `top_addr` = 0. `underflow` remains 1 after a later push 0x055, which succeeds (`top_addr` = 0x055).
- Simultaneous: push 0x0A0, then push and pop with 0x0B0 -> `count` = 1, `top_addr` = 0x0B0, no flags. From empty, push and pop with 0x0C0 -> `count` = 1, `top_addr` = 0x0C0, `underflow` = 1.
- Reset mid-operation: push 3 entries, then assert `rst` in the same cycle as push 0x0DD -> next cycle `count` = 0, `empty` = 1, `top_addr` = 0, flags cleared.

Source files
------------

// File: rtl/ret_stack_pkg.sv
// ret_stack_pkg
//   Shared definitions for the return-address stack and its bench.
//   - ADDR_W_DEF / DEPTH_DEF : default address width and stack depth
//   - stack_op_t             : per-cycle operation derived from {push, pop}
//   - decode_op()            : maps the two strobes onto stack_op_t
package ret_stack_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DEPTH_DEF  = 8;

    typedef enum logic [1:0] {
        OP_NONE    = 2'd0,
        OP_PUSH    = 2'd1,
        OP_POP     = 2'd2,
        OP_REPLACE = 2'd3
    } stack_op_t;

    function automatic stack_op_t decode_op(input logic push, input logic pop);
        stack_op_t op;
        case ({push, pop})
            2'b10:   op = OP_PUSH;
            2'b01:   op = OP_POP;
            2'b11:   op = OP_REPLACE;
            default: op = OP_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ret_stack_mem.sv
// ret_stack_mem
//   DEPTH x ADDR_W storage for the return-address stack. Synchronous write,
//   asynchronous (combinational) read. Contents are not reset.
//   Ports:
//     clk   in  clock
//     we    in  write enable
//     waddr in  write index
//     wdata in  write data
//     raddr in  read index
//     rdata out mem[raddr], combinational
module ret_stack_mem
    import ret_stack_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [ADDR_W-1:0] wdata,
    input  logic [PTR_W-1:0]  raddr,
    output logic [ADDR_W-1:0] rdata
);

    logic [ADDR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ret_addr_stack.sv
// ret_addr_stack
//   Hardware return-address stack beside the PC register. A subroutine call
//   pushes the return PC, a return pops it; top_addr feeds the PC-source mux.
//   push/pop are single-cycle strobes with no back-pressure: every strobe is
//   acted on at the posedge ending the cycle in which it is high; a refused
//   operation is reported through the sticky overflow/underflow flags.
//   Ports:
//     clk, rst   clock, synchronous active-high reset (wins over push/pop)
//     push       store push_addr this cycle
//     pop        remove the top entry this cycle
//     push_addr  return address to store
//     top_addr   current top entry (combinational), 0 when empty
//     empty/full count == 0 / count == DEPTH
//     count      number of valid entries
//     overflow   sticky: push while full
//     underflow  sticky: pop while empty
//   Optional: define RET_STACK_CIRCULAR_EN so that a push while full
//   overwrites the oldest entry instead of being refused.
module ret_addr_stack
    import ret_stack_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_addr,
    output logic [ADDR_W-1:0] top_addr,
    output logic              empty,
    output logic              full,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              underflow
);

    localparam int PTR_W = $clog2(DEPTH);

    // sp is the next free slot; sp_m1 is the current top.
    logic [PTR_W-1:0]  sp;
    logic [PTR_W-1:0]  sp_m1;
    logic [PTR_W-1:0]  sp_next;
    logic [CNT_W-1:0]  count_next;
    logic              set_ovf;
    logic              set_unf;
    logic              mem_we;
    logic [PTR_W-1:0]  mem_waddr;
    logic [ADDR_W-1:0] mem_rdata;
    stack_op_t         op;

    assign sp_m1 = sp - PTR_W'(1);
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    always_comb begin
        op         = decode_op(push, pop);
        sp_next    = sp;
        count_next = count;
        set_ovf    = 1'b0;
        set_unf    = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = sp;
        case (op)
            OP_PUSH: begin
                if (!full) begin
                    mem_we     = 1'b1;
                    sp_next    = sp + PTR_W'(1);
                    count_next = count + CNT_W'(1);
                end else begin
                    set_ovf = 1'b1;
`ifdef RET_STACK_CIRCULAR_EN
                    // When full, slot sp holds the oldest entry (pointer wraps),
                    // so writing there drops it; count stays DEPTH.
                    mem_we  = 1'b1;
                    sp_next = sp + PTR_W'(1);
`endif
                end
            end
            OP_POP: begin
                if (!empty) begin
                    sp_next    = sp_m1;
                    count_next = count - CNT_W'(1);
                end else begin
                    set_unf = 1'b1;
                end
            end
            OP_REPLACE: begin
                if (!empty) begin
                    // Return immediately followed by a call: overwrite the top.
                    mem_we    = 1'b1;
                    mem_waddr = sp_m1;
                end else begin
                    // Nothing to pop: behaves as a plain push, flag the pop.
                    mem_we     = 1'b1;
                    sp_next    = sp + PTR_W'(1);
                    count_next = count + CNT_W'(1);
                    set_unf    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp        <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            sp    <= sp_next;
            count <= count_next;
            if (set_ovf) overflow  <= 1'b1;
            if (set_unf) underflow <= 1'b1;
        end
    end

    ret_stack_mem #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we && !rst),
        .waddr (mem_waddr),
        .wdata (push_addr),
        .raddr (sp_m1),
        .rdata (mem_rdata)
    );

    assign top_addr = empty ? '0 : mem_rdata;

endmodule

// File: tb/tb_ret_addr_stack.sv
// tb_ret_addr_stack
//   Directed bench for ret_addr_stack. A queue-based model tracks the stack
//   contents and flags; a negedge process compares every output against it
//   each cycle and also checks hand-written literal expectations.
module tb_ret_addr_stack;
    import ret_stack_pkg::*;

    localparam int ADDR_W = ADDR_W_DEF;
    localparam int DEPTH  = DEPTH_DEF;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    // ---------------- clock / reset ----------------
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              push = 1'b0;
    logic              pop = 1'b0;
    logic [ADDR_W-1:0] push_addr = '0;
    logic [ADDR_W-1:0] top_addr;
    logic              empty;
    logic              full;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              underflow;

    always #5 clk = ~clk;

    ret_addr_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_addr (push_addr),
        .top_addr  (top_addr),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    // ---------------- model ----------------
    logic [ADDR_W-1:0] exp_q[$];
    logic              m_ovf = 1'b0;
    logic              m_unf = 1'b0;
    logic              m_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
            m_valid = 1'b1;
        end else begin
            case (decode_op(push, pop))
                OP_PUSH: begin
                    if (exp_q.size() < DEPTH) begin
                        exp_q.push_back(push_addr);
                    end else begin
                        m_ovf = 1'b1;
`ifdef RET_STACK_CIRCULAR_EN
                        void'(exp_q.pop_front());
                        exp_q.push_back(push_addr);
`endif
                    end
                end
                OP_POP: begin
                    if (exp_q.size() > 0) void'(exp_q.pop_back());
                    else m_unf = 1'b1;
                end
                OP_REPLACE: begin
                    if (exp_q.size() > 0) begin
                        exp_q[exp_q.size()-1] = push_addr;
                    end else begin
                        exp_q.push_back(push_addr);
                        m_unf = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;

    // literal expectations for the current cycle, set by the driver
    logic              pin_en = 1'b0;
    string             pin_name = "";
    logic [ADDR_W-1:0] pin_top = '0;
    int                pin_cnt = 0;
    logic              pin_ovf = 1'b0;
    logic              pin_unf = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            int sz;
            sz = exp_q.size();
            chk("model.top", int'(top_addr), (sz > 0) ? int'(exp_q[sz-1]) : 0);
            chk("model.count", int'(count), sz);
            chk("model.empty", int'(empty), (sz == 0) ? 1 : 0);
            chk("model.full", int'(full), (sz == DEPTH) ? 1 : 0);
            chk("model.overflow", int'(overflow), int'(m_ovf));
            chk("model.underflow", int'(underflow), int'(m_unf));
        end
        if (pin_en) begin
            chk({pin_name, ".top"}, int'(top_addr), int'(pin_top));
            chk({pin_name, ".count"}, int'(count), pin_cnt);
            chk({pin_name, ".overflow"}, int'(overflow), int'(pin_ovf));
            chk({pin_name, ".underflow"}, int'(underflow), int'(pin_unf));
        end
    end

    // ---------------- driver ----------------
    // Inputs change 1 time unit after posedge; outputs seen at the following
    // negedge reflect the state during the cycle these inputs are applied.
    task automatic step(input logic r, input logic pu, input logic po,
                        input logic [ADDR_W-1:0] a);
        @(posedge clk);
        #1;
        rst = r; push = pu; pop = po; push_addr = a;
        pin_en = 1'b0;
    endtask

    task automatic step_pin(input logic r, input logic pu, input logic po,
                            input logic [ADDR_W-1:0] a, input string name,
                            input logic [ADDR_W-1:0] t, input int c,
                            input logic ov, input logic un);
        step(r, pu, po, a);
        pin_en = 1'b1; pin_name = name; pin_top = t; pin_cnt = c;
        pin_ovf = ov; pin_unf = un;
    endtask

    logic [ADDR_W-1:0] v;

    initial begin
        // reset then idle
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step_pin(0, 0, 0, 0, "reset_idle", 12'h000, 0, 0, 0);

        // LIFO order
        step(0, 1, 0, 12'h010);
        step(0, 1, 0, 12'h020);
        step(0, 1, 0, 12'h030);
        step_pin(0, 0, 1, 0, "lifo_pop1", 12'h030, 3, 0, 0);
        step_pin(0, 0, 1, 0, "lifo_pop2", 12'h020, 2, 0, 0);
        step_pin(0, 0, 1, 0, "lifo_pop3", 12'h010, 1, 0, 0);
        step_pin(0, 0, 0, 0, "lifo_empty", 12'h000, 0, 0, 0);

        // fill and overflow
        for (int i = 0; i < 8; i++) begin
            v = 12'h100 + ADDR_W'(i);
            step(0, 1, 0, v);
        end
        step_pin(0, 1, 0, 12'h1FF, "fill_full", 12'h107, 8, 0, 0);
`ifdef RET_STACK_CIRCULAR_EN
        step_pin(0, 0, 1, 0, "circ_pop0", 12'h1FF, 8, 1, 0);
        for (int i = 1; i < 8; i++) begin
            v = 12'h108 - ADDR_W'(i);
            step_pin(0, 0, 1, 0, "circ_pop", v, 8 - i, 1, 0);
        end
`else
        for (int i = 0; i < 8; i++) begin
            v = 12'h107 - ADDR_W'(i);
            step_pin(0, 0, 1, 0, "ovf_pop", v, 8 - i, 1, 0);
        end
`endif
        step_pin(0, 0, 0, 0, "ovf_drained", 12'h000, 0, 1, 0);

        // underflow
        step(1, 0, 0, 0);
        step_pin(0, 0, 1, 0, "unf_pop", 12'h000, 0, 0, 0);
        step_pin(0, 1, 0, 12'h055, "unf_set", 12'h000, 0, 0, 1);
        step_pin(0, 0, 0, 0, "unf_push", 12'h055, 1, 0, 1);

        // simultaneous push and pop
        step(1, 0, 0, 0);
        step(0, 1, 0, 12'h0A0);
        step_pin(0, 1, 1, 12'h0B0, "sim_before", 12'h0A0, 1, 0, 0);
        step_pin(0, 0, 1, 0, "sim_replace", 12'h0B0, 1, 0, 0);
        step_pin(0, 1, 1, 12'h0C0, "sim_empty_pre", 12'h000, 0, 0, 0);
        step_pin(0, 0, 0, 0, "sim_empty", 12'h0C0, 1, 0, 1);

        // reset mid-operation (flags and entries present beforehand)
        step(0, 1, 0, 12'h0D1);
        step(0, 1, 0, 12'h0D2);
        step(0, 1, 0, 12'h0D3);
        step_pin(1, 1, 0, 12'h0DD, "mid_pre", 12'h0D3, 4, 0, 1);
        step_pin(0, 0, 0, 0, "mid_reset", 12'h000, 0, 0, 0);

        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
